sdram_arbiter: RTL

//  Owns the SDRAM command/address bus. Holds off traffic until power-up init completes, then shares the bus between periodic auto-refresh, the write engine and the read engine.

---
 rtl/sdram_pkg.sv | 24 ++
 rtl/sdram_aref_timer.sv | 35 +++
 rtl/sdram_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings, bus widths and arbiter state codes.
// Commands are packed as {CKE, CS_N, RAS_N, CAS_N, WE_N}.
package sdram_pkg;

  localparam int ADDR_W = 12;
  localparam int CMD_W  = 5;

  localparam logic [CMD_W-1:0] CMD_NOP   = 5'b10111;
  localparam logic [CMD_W-1:0] CMD_PREC  = 5'b10010;
  localparam logic [CMD_W-1:0] CMD_AREF  = 5'b10001;
  localparam logic [CMD_W-1:0] CMD_ACT   = 5'b10011;
  localparam logic [CMD_W-1:0] CMD_READ  = 5'b10101;
  localparam logic [CMD_W-1:0] CMD_WRITE = 5'b10100;

  // A10 high selects all banks for PRECHARGE.
  localparam logic [ADDR_W-1:0] ADDR_ALLBANK = 12'h400;

  localparam logic [2:0] ST_INIT  = 3'd0;
  localparam logic [2:0] ST_ARB   = 3'd1;
  localparam logic [2:0] ST_AREF  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_READ  = 3'd4;

endpackage

// File: rtl/sdram_aref_timer.sv
// Free-running refresh interval counter with a sticky, non-queueing refresh request.
module sdram_aref_timer #(
  parameter int REF_PERIOD = 780
) (
  input  logic S_CLK,
  input  logic RST_N,
  input  logic en,
  input  logic clr,
  output logic aref_req
);

  localparam int TW = $clog2(REF_PERIOD);
  localparam logic [TW-1:0] LAST = TW'(REF_PERIOD - 1);

  logic [TW-1:0] timer;
  logic          expire;

  assign expire = en && (timer == LAST);

  always_ff @(posedge S_CLK or negedge RST_N) begin
    if (!RST_N) begin
      timer    <= '0;
      aref_req <= 1'b0;
    end else begin
      if (en)
        timer <= expire ? '0 : timer + TW'(1);
      // The refresh being entered services any expiry on the same edge.
      if (clr)
        aref_req <= 1'b0;
      else if (expire)
        aref_req <= 1'b1;
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// SDRAM command/address bus owner: init hold-off, periodic refresh, write/read arbitration.
// Optional ARB_ROUND_ROBIN_EN alternates grants when both engines request at once.
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int REF_PERIOD = 780,
  parameter int T_RP       = 2,
  parameter int T_RC       = 7
) (
  input  logic              S_CLK,
  input  logic              RST_N,
  input  logic              init_done,
  input  logic [CMD_W-1:0]  init_cmd,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              wr_req,
  output logic              wr_en,
  input  logic              wr_done,
  input  logic [CMD_W-1:0]  wr_cmd,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              rd_req,
  output logic              rd_en,
  input  logic              rd_done,
  input  logic [CMD_W-1:0]  rd_cmd,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              aref_req,
  output logic [CMD_W-1:0]  sdram_cmd,
  output logic [ADDR_W-1:0] sdram_addr
);

  localparam logic [3:0] SEQ_AR  = 4'(T_RP + 1);
  localparam logic [3:0] SEQ_END = 4'(T_RP + T_RC + 1);

  logic [2:0] state;
  logic [2:0] next_state;
  logic [3:0] seq;
  logic       aref_end;
  logic       tmr_en;
  logic       aref_clr;

  assign aref_end = (seq == SEQ_END);
  // init_done is one-shot: once out of INIT the timer never stops.
  assign tmr_en   = init_done || (state != ST_INIT);
  assign aref_clr = (state == ST_ARB) && aref_req;

  sdram_aref_timer #(
    .REF_PERIOD (REF_PERIOD)
  ) u_timer (
    .S_CLK    (S_CLK),
    .RST_N    (RST_N),
    .en       (tmr_en),
    .clr      (aref_clr),
    .aref_req (aref_req)
  );

`ifdef ARB_ROUND_ROBIN_EN
  logic last_wr;

  always_ff @(posedge S_CLK or negedge RST_N) begin
    if (!RST_N)
      last_wr <= 1'b0;
    else if (state == ST_ARB && next_state == ST_WRITE)
      last_wr <= 1'b1;
    else if (state == ST_ARB && next_state == ST_READ)
      last_wr <= 1'b0;
  end
`endif

  always_comb begin
    next_state = state;
    case (state)
      ST_INIT:  if (init_done) next_state = ST_ARB;
      ST_ARB: begin
        if (aref_req)
          next_state = ST_AREF;
        else if (wr_req && rd_req) begin
`ifdef ARB_ROUND_ROBIN_EN
          next_state = last_wr ? ST_READ : ST_WRITE;
`else
          next_state = ST_WRITE;
`endif
        end else if (wr_req)
          next_state = ST_WRITE;
        else if (rd_req)
          next_state = ST_READ;
      end
      ST_WRITE: if (wr_done)  next_state = ST_ARB;
      ST_READ:  if (rd_done)  next_state = ST_ARB;
      ST_AREF:  if (aref_end) next_state = ST_ARB;
      default:  next_state = ST_INIT;
    endcase
  end

  always_ff @(posedge S_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= ST_INIT;
      wr_en <= 1'b0;
      rd_en <= 1'b0;
      seq   <= 4'd0;
    end else begin
      state <= next_state;
      wr_en <= (next_state == ST_WRITE);
      rd_en <= (next_state == ST_READ);
      seq   <= (state == ST_AREF && !aref_end) ? seq + 4'd1 : 4'd0;
    end
  end

  // Reset forces the idle bus pattern without waiting for a clock.
  always_comb begin
    sdram_cmd  = CMD_NOP;
    sdram_addr = ADDR_ALLBANK;
    if (RST_N) begin
      case (state)
        ST_INIT: begin
          sdram_cmd  = init_cmd;
          sdram_addr = init_addr;
        end
        ST_WRITE: begin
          sdram_cmd  = wr_cmd;
          sdram_addr = wr_addr;
        end
        ST_READ: begin
          sdram_cmd  = rd_cmd;
          sdram_addr = rd_addr;
        end
        ST_AREF: begin
          if (seq == 4'd0)
            sdram_cmd = CMD_PREC;
          else if (seq == SEQ_AR)
            sdram_cmd = CMD_AREF;
        end
        default: ;
      endcase
    end
  end

endmodule
